fifo_sync_param: RTL and testbench

- Parametrised synchronous first-word-fall-through (FWFT) FIFO. It is the successor to the fixed 16x8 SRL FIFO used between the PS/2 receive path and the host-side consumer.
- Width and depth are generic. The block adds an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Storage is a register/distributed-RAM array with separate read and write pointers.

---
 rtl/fifo_sync_param_if.sv | 35 +++
 rtl/fifo_sync_param.sv | 105 ++++++++++
 tb/tb_fifo_sync_param.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// master drives data/requests, slave is the FIFO.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic              read;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              half_full;
  logic              almost_full;
  logic              almost_empty;
  logic              data_present;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic [ADDR_W:0]   peak;

  modport master (
    output data_in, write, read, clr_err,
    input  data_out, full, half_full, almost_full,
    input  almost_empty, data_present, count,
    input  overflow, underflow, peak
  );

  modport slave (
    input  data_in, write, read, clr_err,
    output data_out, full, half_full, almost_full,
    output almost_empty, data_present, count,
    output overflow, underflow, peak
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised FWFT synchronous FIFO with count, level flags, sticky errors.
// Define FIFO_PEAK_EN to build the peak-occupancy register.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic             clk,
  input logic             rst,
  fifo_sync_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] HALF_C  = (ADDR_W+1)'(DEPTH / 2);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_cfg
    $error("fifo_sync_param: AF_LEVEL/AE_LEVEL out of range");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              full, present;
  logic              wr_acc, rd_acc;

  assign full    = (count_q == DEPTH_C);
  assign present = (count_q != '0);
  // A read frees a slot in the same edge, so full+read+write is legal.
  assign wr_acc  = bus.write & (~full | bus.read);
  assign rd_acc  = bus.read & present;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = (bus.write & full & ~bus.read) |
            (ovf_q & ~bus.clr_err);
    unf_d = (bus.read & ~present) |
            (unf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef FIFO_PEAK_EN
  logic [ADDR_W:0] peak_q, peak_d, peak_base;

  always_comb begin
    peak_base = bus.clr_err ? count_q : peak_q;
    peak_d    = (count_d > peak_base) ? count_d : peak_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = '0;
`endif

  assign bus.data_out     = present ? mem_q[rd_ptr_q] : '0;
  assign bus.full         = full;
  assign bus.half_full    = (count_q >= HALF_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.data_present = present;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (default 8x16, AF 14, AE 2).
// Compile with +define+FIFO_PEAK_EN to also exercise the peak register.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_sync_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  fifo_sync_param #(
    .DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.clr_err = 1'b0;
    bus.data_in = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    checks++;
    if (bus.count !== 5'd0 || bus.data_present !== 1'b0 ||
        bus.full !== 1'b0 || bus.half_full !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0 ||
        bus.data_out !== 8'h00 || bus.peak !== 5'd0) begin
      errors++;
      $display("FAIL reset: cnt=%0d dp=%b f=%b hf=%b af=%b ae=%b ov=%b un=%b do=%h pk=%0d, need 0 0 0 0 0 1 0 0 00 0",
               bus.count, bus.data_present, bus.full, bus.half_full,
               bus.almost_full, bus.almost_empty, bus.overflow,
               bus.underflow, bus.data_out, bus.peak);
    end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = (i == 15) ? 8'h10 : 8'(8'h11 + i);
      bus.data_in = d;
      bus.write   = 1'b1;
      step();
      checks++;
      if (bus.count !== 5'(i + 1) || bus.full !== (i + 1 == 16) ||
          bus.almost_full !== (i + 1 >= 14) ||
          bus.half_full !== (i + 1 >= 8) ||
          bus.almost_empty !== (i + 1 <= 2) ||
          bus.data_out !== 8'h11) begin
        errors++;
        $display("FAIL fill[%0d]: cnt=%0d f=%b af=%b hf=%b ae=%b do=%h, need cnt=%0d do=11",
                 i, bus.count, bus.full, bus.almost_full,
                 bus.half_full, bus.almost_empty, bus.data_out, i + 1);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    bus.data_in = 8'hAA;
    bus.write   = 1'b1;
    step();
    idle();
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16 ||
        bus.full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ov=%b cnt=%0d f=%b, need 1 16 1",
               bus.overflow, bus.count, bus.full);
    end
    step();
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ov=%b, need 1", bus.overflow);
    end
    bus.clr_err = 1'b1;
    step();
    idle();
    checks++;
    if (bus.overflow !== 1'b0 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_clr: ov=%b cnt=%0d, need 0 16",
               bus.overflow, bus.count);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    bus.data_in = 8'hBB;
    bus.write   = 1'b1;
    bus.read    = 1'b1;
    step();
    idle();
    checks++;
    if (bus.count !== 5'd16 || bus.data_out !== 8'h12 ||
        bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: cnt=%0d do=%h ov=%b, need 16 12 0",
               bus.count, bus.data_out, bus.overflow);
    end
    for (int k = 0; k < 16; k++) begin
      if (k < 14)       exp = 8'(8'h12 + k);
      else if (k == 14) exp = 8'h10;
      else              exp = 8'hBB;
      checks++;
      if (bus.data_out !== exp) begin
        errors++;
        $display("FAIL drain[%0d]: do=%h, need %h", k, bus.data_out, exp);
      end
      bus.read = 1'b1;
      step();
    end
    idle();
    checks++;
    if (bus.count !== 5'd0 || bus.data_present !== 1'b0 ||
        bus.data_out !== 8'h00 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL drained: cnt=%0d dp=%b do=%h un=%b, need 0 0 00 0",
               bus.count, bus.data_present, bus.data_out, bus.underflow);
    end
  endtask

  task automatic test_underflow();
    bus.read = 1'b1;
    step();
    idle();
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd0 ||
        bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL underflow: un=%b cnt=%0d do=%h, need 1 0 00",
               bus.underflow, bus.count, bus.data_out);
    end
    bus.clr_err = 1'b1;
    step();
    idle();
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clr: un=%b, need 0", bus.underflow);
    end
  endtask

  task automatic test_empty_rw();
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    bus.data_in = 8'h5A;
    step();
    idle();
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd1 ||
        bus.data_out !== 8'h5A || bus.data_present !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw: un=%b cnt=%0d do=%h dp=%b, need 1 1 5a 1",
               bus.underflow, bus.count, bus.data_out, bus.data_present);
    end
    // New underflow in the clr_err cycle must win.
    bus.read    = 1'b1;
    step();
    bus.clr_err = 1'b1;
    step();
    idle();
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL set_wins: un=%b cnt=%0d, need 1 0",
               bus.underflow, bus.count);
    end
    bus.clr_err = 1'b1;
    step();
    idle();
  endtask

  task automatic test_stream();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic       wr, rd;
    int         nw = 0;
    int         nr = 0;
    int         maxc = 0;
    int         cyc = 0;
    while (nr < 40 && cyc < 600) begin
      wr = (nw < 40) && (q.size() < 12) && ($urandom_range(0, 2) != 0);
      rd = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      exp = (q.size() > 0) ? q[0] : 8'h00;
      checks++;
      if (bus.data_out !== exp) begin
        errors++;
        $display("FAIL stream_data[%0d]: do=%h, need %h",
                 nr, bus.data_out, exp);
      end
      bus.write   = wr;
      bus.read    = rd;
      bus.data_in = 8'(nw);
      step();
      if (rd) begin
        void'(q.pop_front());
        nr++;
      end
      if (wr) begin
        q.push_back(8'(nw));
        nw++;
      end
      if (q.size() > maxc) maxc = q.size();
      checks++;
      if (bus.count !== 5'(q.size())) begin
        errors++;
        $display("FAIL stream_count: cnt=%0d, need %0d",
                 bus.count, q.size());
      end
      cyc++;
    end
    idle();
    checks++;
    if (nr != 40) begin
      errors++;
      $display("FAIL stream_timeout: read %0d words, need 40", nr);
    end
    checks++;
`ifdef FIFO_PEAK_EN
    if (bus.peak !== 5'(maxc)) begin
      errors++;
      $display("FAIL peak: pk=%0d, need %0d", bus.peak, maxc);
    end
`else
    if (bus.peak !== 5'd0) begin
      errors++;
      $display("FAIL peak_off: pk=%0d, need 0 (max seen %0d)",
               bus.peak, maxc);
    end
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      bus.write   = 1'b1;
      bus.data_in = 8'(8'hC0 + i);
      step();
    end
    idle();
    checks++;
    if (bus.count !== 5'd5) begin
      errors++;
      $display("FAIL pre_rst: cnt=%0d, need 5", bus.count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.data_present !== 1'b0 ||
        bus.almost_empty !== 1'b1 || bus.data_out !== 8'h00 ||
        bus.peak !== 5'd0) begin
      errors++;
      $display("FAIL async_rst: cnt=%0d dp=%b ae=%b do=%h pk=%0d, need 0 0 1 00 0",
               bus.count, bus.data_present, bus.almost_empty,
               bus.data_out, bus.peak);
    end
    step();
    rst = 1'b0;
    bus.write   = 1'b1;
    bus.data_in = 8'h77;
    step();
    idle();
    checks++;
    if (bus.count !== 5'd1 || bus.data_out !== 8'h77) begin
      errors++;
      $display("FAIL post_rst: cnt=%0d do=%h, need 1 77",
               bus.count, bus.data_out);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_empty_rw();
    test_stream();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
